// File: rtl/sw_pkg.sv
// Shared widths and the arbiter state encoding for the Smith-Waterman core wrapper.
package sw_pkg;

  localparam int SEQ_W   = 256;
  localparam int LEN_W   = 8;
  localparam int SCORE_W = 10;
  localparam int POS_W   = 7;
  localparam int MAX_LEN = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_BUSY   = 2'd2,
    S_RETURN = 2'd3
  } sw_arb_state_t;

endpackage

// File: rtl/sw_rr_picker.sv
// Combinational round-robin search: first set valid bit at ptr, ptr+1, ... (mod NUM_REQ).
module sw_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic               any,
  output logic [PTR_W-1:0]   winner
);

  // Walk the search order backwards so the candidate nearest ptr is assigned last.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[PTR_W'((int'(ptr) + i) % NUM_REQ)]) begin
        any    = 1'b1;
        winner = PTR_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/sw_core_arbiter.sv
// Round-robin arbiter sharing one SW_core between NUM_REQ requesters.
// Optional length check on accepted jobs: define SW_ARB_LEN_CHECK_EN.
module sw_core_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int SEQ_W   = sw_pkg::SEQ_W,
  parameter int LEN_W   = sw_pkg::LEN_W,
  parameter int SCORE_W = sw_pkg::SCORE_W,
  parameter int POS_W   = sw_pkg::POS_W
) (
  input  logic                     avm_clk,
  input  logic                     avm_rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*SEQ_W-1:0] req_ref,
  input  logic [NUM_REQ*SEQ_W-1:0] req_read,
  input  logic [NUM_REQ*LEN_W-1:0] req_ref_len,
  input  logic [NUM_REQ*LEN_W-1:0] req_read_len,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [SCORE_W-1:0]       rsp_score,
  output logic [POS_W-1:0]         rsp_row,
  output logic [POS_W-1:0]         rsp_column,
  output logic                     rsp_err,
  output logic                     core_valid,
  input  logic                     core_ready,
  output logic [SEQ_W-1:0]         core_ref,
  output logic [SEQ_W-1:0]         core_read,
  output logic [LEN_W-1:0]         core_ref_len,
  output logic [LEN_W-1:0]         core_read_len,
  input  logic                     core_rsp_valid,
  output logic                     core_rsp_ready,
  input  logic [SCORE_W-1:0]       core_score,
  input  logic [POS_W-1:0]         core_row,
  input  logic [POS_W-1:0]         core_column,
  output logic [1:0]               dbg_state
);
  import sw_pkg::*;

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  sw_arb_state_t state, state_nxt;
  logic [PTR_W-1:0] ptr, owner, winner;
  logic             any;
  logic             len_bad;
  logic [SEQ_W-1:0] win_ref, win_read;
  logic [LEN_W-1:0] win_ref_len, win_read_len;

  sw_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .valid  (req_valid),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  always_comb begin
    win_ref      = '0;
    win_read     = '0;
    win_ref_len  = '0;
    win_read_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        win_ref      = req_ref[i*SEQ_W +: SEQ_W];
        win_read     = req_read[i*SEQ_W +: SEQ_W];
        win_ref_len  = req_ref_len[i*LEN_W +: LEN_W];
        win_read_len = req_read_len[i*LEN_W +: LEN_W];
      end
    end
  end

`ifdef SW_ARB_LEN_CHECK_EN
  logic rsp_err_q;
  assign len_bad = (win_ref_len == '0) || (win_ref_len > LEN_W'(MAX_LEN)) ||
                   (win_read_len == '0) || (win_read_len > LEN_W'(MAX_LEN));
  assign rsp_err = rsp_err_q;
`else
  assign len_bad = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge avm_clk) begin
    if (avm_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Handshake: a transfer happens in any cycle where valid and ready are both high;
  // valid, once raised, is held with stable payload until that cycle.
  always_comb begin
    state_nxt      = state;
    req_ready      = '0;
    core_valid     = 1'b0;
    core_rsp_ready = 1'b0;
    rsp_valid      = '0;
    case (state)
      S_IDLE: begin
        if (any) begin
          req_ready = ONE << winner;
          state_nxt = len_bad ? S_RETURN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_valid = 1'b1;
        if (core_ready) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        core_rsp_ready = 1'b1;
        if (core_rsp_valid) state_nxt = S_RETURN;
      end
      S_RETURN: begin
        rsp_valid = ONE << owner;
        if (rsp_ready[owner]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      ptr           <= '0;
      owner         <= '0;
      core_ref      <= '0;
      core_read     <= '0;
      core_ref_len  <= '0;
      core_read_len <= '0;
      rsp_score     <= '0;
      rsp_row       <= '0;
      rsp_column    <= '0;
`ifdef SW_ARB_LEN_CHECK_EN
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            owner         <= winner;
            core_ref      <= win_ref;
            core_read     <= win_read;
            core_ref_len  <= win_ref_len;
            core_read_len <= win_read_len;
`ifdef SW_ARB_LEN_CHECK_EN
            if (len_bad) begin
              rsp_score  <= '0;
              rsp_row    <= '0;
              rsp_column <= '0;
              rsp_err_q  <= 1'b1;
            end
`endif
          end
        end
        S_BUSY: begin
          if (core_rsp_valid) begin
            rsp_score  <= core_score;
            rsp_row    <= core_row;
            rsp_column <= core_column;
`ifdef SW_ARB_LEN_CHECK_EN
            rsp_err_q  <= 1'b0;
`endif
          end
        end
        S_RETURN: begin
          if (rsp_ready[owner])
            ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_sw_core_arbiter.sv
// Directed bench for sw_core_arbiter: a 2-requester instance plus a 3-requester
// instance for pointer wrap; the core side is driven by hand.
module tb_sw_core_arbiter;

  localparam logic [255:0] R0 = {8{32'h0123_4567}};
  localparam logic [255:0] R1 = {8{32'h89AB_CDEF}};
  localparam logic [255:0] D0 = {8{32'h1111_2222}};
  localparam logic [255:0] D1 = {8{32'h3333_4444}};

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [511:0] req_ref, req_read;
  logic [15:0]  req_ref_len, req_read_len;
  logic [9:0]   rsp_score;
  logic [6:0]   rsp_row, rsp_column;
  logic         rsp_err, core_valid, core_rsp_ready;
  logic [255:0] core_ref, core_read;
  logic [7:0]   core_ref_len, core_read_len;
  logic [1:0]   dbg_state;

  logic         core_ready, core_rsp_valid;
  logic [9:0]   core_score;
  logic [6:0]   core_row, core_column;

  logic [2:0]   req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [767:0] req_ref3, req_read3;
  logic [23:0]  req_ref_len3, req_read_len3;
  logic [9:0]   rsp_score3;
  logic [6:0]   rsp_row3, rsp_column3;
  logic         rsp_err3, core_valid3, core_rsp_ready3;
  logic [255:0] core_ref3, core_read3;
  logic [7:0]   core_ref_len3, core_read_len3;
  logic [1:0]   dbg_state3;

  always #5 clk = ~clk;

  sw_core_arbiter #(.NUM_REQ(2)) u_dut (
    .avm_clk(clk), .avm_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ref(req_ref), .req_read(req_read),
    .req_ref_len(req_ref_len), .req_read_len(req_read_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_score(rsp_score), .rsp_row(rsp_row), .rsp_column(rsp_column), .rsp_err(rsp_err),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_ref(core_ref), .core_read(core_read),
    .core_ref_len(core_ref_len), .core_read_len(core_read_len),
    .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
    .core_score(core_score), .core_row(core_row), .core_column(core_column),
    .dbg_state(dbg_state)
  );

  sw_core_arbiter #(.NUM_REQ(3)) u_dut3 (
    .avm_clk(clk), .avm_rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_ref(req_ref3), .req_read(req_read3),
    .req_ref_len(req_ref_len3), .req_read_len(req_read_len3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_score(rsp_score3), .rsp_row(rsp_row3), .rsp_column(rsp_column3), .rsp_err(rsp_err3),
    .core_valid(core_valid3), .core_ready(core_ready),
    .core_ref(core_ref3), .core_read(core_read3),
    .core_ref_len(core_ref_len3), .core_read_len(core_read_len3),
    .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready3),
    .core_score(core_score), .core_row(core_row), .core_column(core_column),
    .dbg_state(dbg_state3)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full job with both requesters held valid; grant must go to exp_w.
  task automatic rr_job(input int exp_w, input logic [9:0] sc);
    check("rr_grant", req_ready, 256'(2'b01 << exp_w));
    tick();
    check("rr_issue_no_grant", req_ready, 0);
    check("rr_issue_core_valid", core_valid, 1);
    check("rr_core_ref", core_ref, (exp_w == 1) ? R1 : R0);
    tick();
    check("rr_busy_no_grant", req_ready, 0);
    core_rsp_valid = 1'b1;
    core_score     = sc;
    tick();
    core_rsp_valid = 1'b0;
    check("rr_rsp_valid", rsp_valid, 256'(2'b01 << exp_w));
    check("rr_rsp_score", rsp_score, sc);
    check("rr_return_no_grant", req_ready, 0);
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0;
    req_ref = {R1, R0}; req_read = {D1, D0};
    req_ref_len = {8'd100, 8'd50}; req_read_len = {8'd120, 8'd60};
    core_ready = 1'b0; core_rsp_valid = 1'b0;
    core_score = '0; core_row = '0; core_column = '0;
    req_valid3 = '0; rsp_ready3 = '0;
    req_ref3 = {R0, R1, R0}; req_read3 = {D0, D1, D0};
    req_ref_len3 = {8'd10, 8'd20, 8'd30}; req_read_len3 = {8'd11, 8'd21, 8'd31};

    // Reset values
    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_core_valid", core_valid, 0);
    check("rst_core_rsp_ready", core_rsp_ready, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_state", dbg_state, 0);
    check("rst_core_ref", core_ref, 0);
    check("rst_rsp_score", rsp_score, 0);
    rst = 1'b0;
    tick();

    // Single job from requester 1, result 37/100/120 after a long core run
    core_ready = 1'b1;
    req_valid  = 2'b10;
    #1;
    check("t1_req_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("t1_core_valid", core_valid, 1);
    check("t1_core_ref", core_ref, R1);
    check("t1_core_read", core_read, D1);
    check("t1_core_ref_len", core_ref_len, 100);
    check("t1_core_read_len", core_read_len, 120);
    tick();
    check("t1_busy_core_valid", core_valid, 0);
    check("t1_busy_core_rsp_ready", core_rsp_ready, 1);
    repeat (8) tick();
    check("t1_wait_rsp_valid", rsp_valid, 0);
    core_rsp_valid = 1'b1; core_score = 10'd37; core_row = 7'd100; core_column = 7'd120;
    tick();
    core_rsp_valid = 1'b0; core_score = 10'd5; core_row = 7'd1; core_column = 7'd2;
    check("t1_rsp_valid", rsp_valid, 2'b10);
    check("t1_rsp_score", rsp_score, 37);
    check("t1_rsp_row", rsp_row, 100);
    check("t1_rsp_column", rsp_column, 120);
    check("t1_rsp_err", rsp_err, 0);
    rsp_ready = 2'b01;
    tick();
    check("t1_nonowner_ignored", rsp_valid, 2'b10);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    check("t1_back_idle", dbg_state, 0);
    check("t1_rsp_valid_low", rsp_valid, 0);

    // Both requesters continuously valid: alternating grants
    req_valid = 2'b11;
    #1;
    rr_job(0, 10'd11);
    rr_job(1, 10'd12);
    rr_job(0, 10'd13);
    rr_job(1, 10'd14);
    req_valid = 2'b00;
    tick();

    // Stalls on both handshakes: everything must hold
    core_ready = 1'b0;
    req_valid  = 2'b01;
    #1;
    check("t3_req_ready", req_ready, 2'b01);
    tick();
    req_ref = {R1, ~R0};
    for (int i = 0; i < 5; i++) begin
      check("t3_core_valid_hold", core_valid, 1);
      check("t3_core_ref_hold", core_ref, R0);
      check("t3_no_grant_issue", req_ready, 0);
      tick();
    end
    core_ready = 1'b1;
    tick();
    core_rsp_valid = 1'b1; core_score = 10'd55; core_row = 7'd3; core_column = 7'd4;
    tick();
    core_rsp_valid = 1'b0; core_score = 10'd0;
    for (int i = 0; i < 3; i++) begin
      check("t3_rsp_valid_hold", rsp_valid, 2'b01);
      check("t3_rsp_score_hold", rsp_score, 55);
      check("t3_rsp_column_hold", rsp_column, 4);
      check("t3_no_grant_return", req_ready, 0);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    req_ref   = {R1, R0};
    check("t3_back_idle", dbg_state, 0);

    // Reset while busy discards the job
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    check("t4_in_busy", dbg_state, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_state", dbg_state, 0);
    check("t4_core_rsp_ready", core_rsp_ready, 0);
    check("t4_rsp_valid", rsp_valid, 0);
    check("t4_core_ref", core_ref, 0);
    req_valid = 2'b11;
    #1;
    check("t4_grant_req0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    core_rsp_valid = 1'b1; core_score = 10'd99;
    tick();
    core_rsp_valid = 1'b0;
    check("t4_rsp_valid", rsp_valid, 2'b01);
    check("t4_rsp_score", rsp_score, 99);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;

    // Zero read length
    req_read_len = {8'd120, 8'd0};
    req_valid    = 2'b01;
    #1;
    check("t5_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
`ifdef SW_ARB_LEN_CHECK_EN
    check("t5_no_core_valid", core_valid, 0);
    check("t5_rsp_valid", rsp_valid, 2'b01);
    check("t5_rsp_err", rsp_err, 1);
    check("t5_rsp_score", rsp_score, 0);
`else
    check("t5_core_valid", core_valid, 1);
    check("t5_core_read_len", core_read_len, 0);
    check("t5_rsp_err", rsp_err, 0);
    tick();
    core_rsp_valid = 1'b1; core_score = 10'd7;
    tick();
    core_rsp_valid = 1'b0;
    check("t5_rsp_valid", rsp_valid, 2'b01);
`endif
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    req_read_len = {8'd120, 8'd60};
    check("t5_back_idle", dbg_state, 0);

    // Pointer wrap on the 3-requester instance
    req_valid3 = 3'b100;
    #1;
    check("t6_grant2", req_ready3, 3'b100);
    tick();
    req_valid3 = 3'b000;
    check("t6_core_ref", core_ref3, R0);
    check("t6_core_ref_len", core_ref_len3, 10);
    tick();
    core_rsp_valid = 1'b1; core_score = 10'd21;
    tick();
    core_rsp_valid = 1'b0;
    check("t6_rsp_valid", rsp_valid3, 3'b100);
    check("t6_rsp_score", rsp_score3, 21);
    rsp_ready3 = 3'b100;
    tick();
    rsp_ready3 = 3'b000;
    req_valid3 = 3'b101;
    #1;
    check("t6_wrap_grant0", req_ready3, 3'b001);
    req_valid3 = 3'b000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
